// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the hardwired control sequencer: opcodes, state
// encoding, IR field positions and an opcode classifier.
package cpu_defs;

  localparam int OP_W      = 5;
  localparam int REG_IDX_W = 4;

  // IR field bit positions
  localparam int IR_OP_MSB = 31;
  localparam int IR_OP_LSB = 27;
  localparam int IR_RA_MSB = 26;
  localparam int IR_RA_LSB = 23;
  localparam int IR_RB_MSB = 22;
  localparam int IR_RB_LSB = 19;
  localparam int IR_RC_MSB = 18;
  localparam int IR_RC_LSB = 15;

  // Opcodes
  localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OP_W-1:0] OP_AND  = 5'b00101;
  localparam logic [OP_W-1:0] OP_OR   = 5'b00110;
  localparam logic [OP_W-1:0] OP_SHR  = 5'b00111;
  localparam logic [OP_W-1:0] OP_SHRA = 5'b01000;
  localparam logic [OP_W-1:0] OP_SHL  = 5'b01001;
  localparam logic [OP_W-1:0] OP_ROR  = 5'b01010;
  localparam logic [OP_W-1:0] OP_ROL  = 5'b01011;
  localparam logic [OP_W-1:0] OP_MUL  = 5'b01111;
  localparam logic [OP_W-1:0] OP_DIV  = 5'b10000;
  localparam logic [OP_W-1:0] OP_NEG  = 5'b10001;
  localparam logic [OP_W-1:0] OP_NOT  = 5'b10010;
  localparam logic [OP_W-1:0] OP_NOP  = 5'b11010;
  localparam logic [OP_W-1:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T1W  = 4'd3,
    S_T2   = 4'd4,
    S_T3   = 4'd5,
    S_T4   = 4'd6,
    S_T5   = 4'd7,
    S_T6   = 4'd8,
    S_HALT = 4'd9
  } state_t;

  typedef enum logic [2:0] {
    CLS_BINARY  = 3'd0,
    CLS_MULDIV  = 3'd1,
    CLS_UNARY   = 3'd2,
    CLS_NOP     = 3'd3,
    CLS_HALT    = 3'd4,
    CLS_ILLEGAL = 3'd5
  } op_class_t;

  // Groups an opcode by the execute sequence it needs
  function automatic op_class_t classify(input logic [OP_W-1:0] op);
    op_class_t cls;
    if (op >= OP_ADD && op <= OP_ROL) begin
      cls = CLS_BINARY;
    end else if (op == OP_MUL || op == OP_DIV) begin
      cls = CLS_MULDIV;
    end else if (op == OP_NEG || op == OP_NOT) begin
      cls = CLS_UNARY;
    end else if (op == OP_NOP) begin
      cls = CLS_NOP;
    end else if (op == OP_HALT) begin
      cls = CLS_HALT;
    end else begin
      cls = CLS_ILLEGAL;
    end
    return cls;
  endfunction

endpackage

// File: rtl/reg_select_decoder.sv
// Converts a register index plus enable into a one-hot register strobe vector.
module reg_select_decoder #(
  parameter int NREG = 16,
  parameter int IW   = 4
) (
  input  logic [IW-1:0]   index,
  input  logic            enable,
  output logic [NREG-1:0] onehot
);

  // One bit set at the selected index, nothing when disabled
  always_comb begin
    if (enable) begin
      onehot = NREG'(1) << index;
    end else begin
      onehot = '0;
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit for the shared-bus datapath. Steps fetch (T0..T2)
// and execute (T3..T6) and owns every register load and bus drive strobe.
// All strobes are registered from the next state, except MDRin which
// qualifies the registered read request with the live mem_ready.
module control_sequencer
  import cpu_defs::*;
#(
  parameter int OPW  = 5,
  parameter int NREG = 16,
  parameter int IRW  = 32
) (
  input  logic            clock,
  input  logic            clear,
  input  logic            start,
  input  logic [IRW-1:0]  ir,
  input  logic            mem_ready,
  output logic            read,
  output logic            MARin,
  output logic            MDRin,
  output logic            IRin,
  output logic            PCin,
  output logic            Yin,
  output logic            Zin,
  output logic            HIin,
  output logic            LOin,
  output logic            PCout,
  output logic            MDRout,
  output logic            ZHIout,
  output logic            ZLOout,
  output logic            IncPC,
  output logic [OPW-1:0]  operation,
  output logic [NREG-1:0] Rin,
  output logic [NREG-1:0] Rout,
  output logic            run,
  output logic            illegal
);

  state_t                 state, state_next;
  logic [OP_W-1:0]        op_r, op_next;
  logic [REG_IDX_W-1:0]   ra_r, rb_r, rc_r;
  logic [REG_IDX_W-1:0]   ra_next, rb_next, rc_next;
  op_class_t              cls_now, cls_next;

  logic n_read, n_mar_in, n_ir_in, n_pc_in, n_y_in, n_z_in, n_hi_in, n_lo_in;
  logic n_pc_out, n_mdr_out, n_zhi_out, n_zlo_out, n_inc_pc, n_run, n_illegal;
  logic [OPW-1:0]       n_operation;
  logic                 rin_en, rout_en;
  logic [REG_IDX_W-1:0] rin_idx, rout_idx;
  logic [NREG-1:0]      rin_dec, rout_dec;

  // Instruction bits below Rc carry immediates the sequencer never needs
  logic unused_ir_bits;
  assign unused_ir_bits = ^ir[IR_RC_LSB-1:0];

  assign cls_now  = classify(op_r);
  assign cls_next = classify(op_next);

  // Memory data is captured in whichever read cycle sees mem_ready
  assign MDRin = read & mem_ready;

  // Next state and field capture; fields are latched on the T2->T3 edge
  always_comb begin
    state_next = state;
    op_next    = op_r;
    ra_next    = ra_r;
    rb_next    = rb_r;
    rc_next    = rc_r;
    case (state)
      S_IDLE, S_HALT: begin
        if (start) state_next = S_T0;
        else       state_next = state;
      end
      S_T0: state_next = S_T1;
      S_T1, S_T1W: begin
        if (mem_ready) state_next = S_T2;
        else           state_next = S_T1W;
      end
      S_T2: begin
        state_next = S_T3;
        op_next    = ir[IR_OP_MSB:IR_OP_LSB];
        ra_next    = ir[IR_RA_MSB:IR_RA_LSB];
        rb_next    = ir[IR_RB_MSB:IR_RB_LSB];
        rc_next    = ir[IR_RC_MSB:IR_RC_LSB];
      end
      S_T3: begin
        case (cls_now)
          CLS_BINARY, CLS_MULDIV, CLS_UNARY: state_next = S_T4;
          CLS_HALT:                          state_next = S_HALT;
          default:                           state_next = S_T0;
        endcase
      end
      S_T4: begin
        if (cls_now == CLS_UNARY) state_next = S_T0;
        else                      state_next = S_T5;
      end
      S_T5: begin
        if (cls_now == CLS_MULDIV) state_next = S_T6;
        else                       state_next = S_T0;
      end
      S_T6:    state_next = S_T0;
      default: state_next = S_IDLE;
    endcase
  end

  // Strobe pattern for the state being entered, from the fields it will hold
  always_comb begin
    n_read = 1'b0; n_mar_in = 1'b0; n_ir_in = 1'b0; n_pc_in = 1'b0;
    n_y_in = 1'b0; n_z_in = 1'b0; n_hi_in = 1'b0; n_lo_in = 1'b0;
    n_pc_out = 1'b0; n_mdr_out = 1'b0; n_zhi_out = 1'b0; n_zlo_out = 1'b0;
    n_inc_pc = 1'b0; n_illegal = 1'b0;
    n_operation = '0;
    rin_en = 1'b0; rin_idx = ra_next;
    rout_en = 1'b0; rout_idx = rb_next;
    n_run = (state_next != S_IDLE) && (state_next != S_HALT);
    case (state_next)
      S_T0: begin
        n_pc_out = 1'b1; n_mar_in = 1'b1; n_inc_pc = 1'b1; n_z_in = 1'b1;
      end
      S_T1: begin
        n_zlo_out = 1'b1; n_pc_in = 1'b1; n_read = 1'b1;
      end
      S_T1W: n_read = 1'b1;
      S_T2: begin
        n_mdr_out = 1'b1; n_ir_in = 1'b1;
      end
      S_T3: begin
        case (cls_next)
          CLS_BINARY: begin
            rout_en = 1'b1; rout_idx = rb_next; n_y_in = 1'b1;
          end
          CLS_MULDIV: begin
            rout_en = 1'b1; rout_idx = ra_next; n_y_in = 1'b1;
          end
          CLS_UNARY: begin
            rout_en = 1'b1; rout_idx = rb_next; n_z_in = 1'b1;
            n_operation = OPW'(op_next);
          end
          CLS_ILLEGAL: n_illegal = 1'b1;
          default: n_illegal = 1'b0;
        endcase
      end
      S_T4: begin
        case (cls_next)
          CLS_BINARY: begin
            rout_en = 1'b1; rout_idx = rc_next; n_z_in = 1'b1;
            n_operation = OPW'(op_next);
          end
          CLS_MULDIV: begin
            rout_en = 1'b1; rout_idx = rb_next; n_z_in = 1'b1;
            n_operation = OPW'(op_next);
          end
          default: begin
            n_zlo_out = 1'b1; rin_en = 1'b1;
          end
        endcase
      end
      S_T5: begin
        n_zlo_out = 1'b1;
        if (cls_next == CLS_MULDIV) n_lo_in = 1'b1;
        else                        rin_en  = 1'b1;
      end
      S_T6: begin
        n_zhi_out = 1'b1; n_hi_in = 1'b1;
      end
      default: n_run = 1'b0;
    endcase
  end

  reg_select_decoder #(.NREG(NREG), .IW(REG_IDX_W)) u_rin_dec (
    .index  (rin_idx),
    .enable (rin_en),
    .onehot (rin_dec)
  );

  reg_select_decoder #(.NREG(NREG), .IW(REG_IDX_W)) u_rout_dec (
    .index  (rout_idx),
    .enable (rout_en),
    .onehot (rout_dec)
  );

  // State, latched fields and registered strobes; clear abandons everything
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state <= S_IDLE;
      op_r <= '0; ra_r <= '0; rb_r <= '0; rc_r <= '0;
      read <= 1'b0; MARin <= 1'b0; IRin <= 1'b0; PCin <= 1'b0;
      Yin <= 1'b0; Zin <= 1'b0; HIin <= 1'b0; LOin <= 1'b0;
      PCout <= 1'b0; MDRout <= 1'b0; ZHIout <= 1'b0; ZLOout <= 1'b0;
      IncPC <= 1'b0; operation <= '0; Rin <= '0; Rout <= '0;
      run <= 1'b0; illegal <= 1'b0;
    end else begin
      state <= state_next;
      op_r <= op_next; ra_r <= ra_next; rb_r <= rb_next; rc_r <= rc_next;
      read <= n_read; MARin <= n_mar_in; IRin <= n_ir_in; PCin <= n_pc_in;
      Yin <= n_y_in; Zin <= n_z_in; HIin <= n_hi_in; LOin <= n_lo_in;
      PCout <= n_pc_out; MDRout <= n_mdr_out; ZHIout <= n_zhi_out; ZLOout <= n_zlo_out;
      IncPC <= n_inc_pc; operation <= n_operation; Rin <= rin_dec; Rout <= rout_dec;
      run <= n_run; illegal <= n_illegal;
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: a reference model expands each
// instruction into its expected per-cycle strobe list from the opcode rules.
module tb_control_sequencer;

  logic        clock, clear, start, mem_ready;
  logic [31:0] ir;
  logic read, MARin, MDRin, IRin, PCin, Yin, Zin, HIin, LOin;
  logic PCout, MDRout, ZHIout, ZLOout, IncPC, run, illegal;
  logic [4:0]  operation;
  logic [15:0] Rin, Rout;

  control_sequencer #(.OPW(5), .NREG(16), .IRW(32)) dut (
    .clock(clock), .clear(clear), .start(start), .ir(ir), .mem_ready(mem_ready),
    .read(read), .MARin(MARin), .MDRin(MDRin), .IRin(IRin), .PCin(PCin),
    .Yin(Yin), .Zin(Zin), .HIin(HIin), .LOin(LOin), .PCout(PCout),
    .MDRout(MDRout), .ZHIout(ZHIout), .ZLOout(ZLOout), .IncPC(IncPC),
    .operation(operation), .Rin(Rin), .Rout(Rout), .run(run), .illegal(illegal)
  );

  typedef struct packed {
    logic run, illegal, read, mdr_in, mar_in, ir_in, pc_in, y_in, z_in;
    logic hi_in, lo_in, pc_out, mdr_out, zhi_out, zlo_out, inc_pc;
    logic [4:0]  operation;
    logic [15:0] rin, rout;
  } outs_t;

  typedef struct {
    logic [31:0] instr;
    int          w;
    logic [15:0] rout_y, rout_op, rin_all;
    logic [4:0]  op_seen;
    int          reads, lohi, ills;
  } vec_t;

  int    checks = 0;
  int    failures = 0;
  outs_t exp_q[$];
  outs_t obs_q[$];
  vec_t  vecs[8];
  logic [4:0] legal_ops[15];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic outs_t sample();
    outs_t s;
    s.run = run; s.illegal = illegal; s.read = read; s.mdr_in = MDRin;
    s.mar_in = MARin; s.ir_in = IRin; s.pc_in = PCin; s.y_in = Yin; s.z_in = Zin;
    s.hi_in = HIin; s.lo_in = LOin; s.pc_out = PCout; s.mdr_out = MDRout;
    s.zhi_out = ZHIout; s.zlo_out = ZLOout; s.inc_pc = IncPC;
    s.operation = operation; s.rin = Rin; s.rout = Rout;
    return s;
  endfunction

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, want);
    end
  endtask

  task automatic check_outs(input string name, input outs_t got, input outs_t want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, want);
    end
  endtask

  // Bus drivers must never collide
  always @(negedge clock) begin
    if (!clear) begin
      checks++;
      if (int'(PCout) + int'(MDRout) + int'(ZHIout) + int'(ZLOout) + $countones(Rout) > 1) begin
        failures++;
        $display("FAIL bus_onehot t=%0t drivers PCout=%b MDRout=%b ZHIout=%b ZLOout=%b Rout=%h expected at most one",
                 $time, PCout, MDRout, ZHIout, ZLOout, Rout);
      end
    end
  end

  // Expected strobe list for one instruction; w = extra read cycles
  task automatic build_expect(input logic [31:0] instr, input int w);
    outs_t b, s;
    int op = int'(instr[31:27]);
    int ra = int'(instr[26:23]);
    int rb = int'(instr[22:19]);
    int rc = int'(instr[18:15]);
    exp_q.delete();
    b = '0; b.run = 1'b1;
    s = b; s.pc_out = 1'b1; s.mar_in = 1'b1; s.inc_pc = 1'b1; s.z_in = 1'b1; exp_q.push_back(s);
    s = b; s.zlo_out = 1'b1; s.pc_in = 1'b1; s.read = 1'b1; s.mdr_in = (w == 0); exp_q.push_back(s);
    for (int i = 1; i <= w; i++) begin
      s = b; s.read = 1'b1; s.mdr_in = (i == w); exp_q.push_back(s);
    end
    s = b; s.mdr_out = 1'b1; s.ir_in = 1'b1; exp_q.push_back(s);
    if (op >= 3 && op <= 11) begin
      s = b; s.rout = 16'd1 << rb; s.y_in = 1'b1; exp_q.push_back(s);
      s = b; s.rout = 16'd1 << rc; s.operation = 5'(op); s.z_in = 1'b1; exp_q.push_back(s);
      s = b; s.zlo_out = 1'b1; s.rin = 16'd1 << ra; exp_q.push_back(s);
    end else if (op == 15 || op == 16) begin
      s = b; s.rout = 16'd1 << ra; s.y_in = 1'b1; exp_q.push_back(s);
      s = b; s.rout = 16'd1 << rb; s.operation = 5'(op); s.z_in = 1'b1; exp_q.push_back(s);
      s = b; s.zlo_out = 1'b1; s.lo_in = 1'b1; exp_q.push_back(s);
      s = b; s.zhi_out = 1'b1; s.hi_in = 1'b1; exp_q.push_back(s);
    end else if (op == 17 || op == 18) begin
      s = b; s.rout = 16'd1 << rb; s.operation = 5'(op); s.z_in = 1'b1; exp_q.push_back(s);
      s = b; s.zlo_out = 1'b1; s.rin = 16'd1 << ra; exp_q.push_back(s);
    end else if (op == 26 || op == 27) begin
      exp_q.push_back(b);
    end else begin
      s = b; s.illegal = 1'b1; exp_q.push_back(s);
    end
  endtask

  // Drives one instruction from its T0 cycle and compares every cycle
  task automatic run_instr(input logic [31:0] instr, input int w, input bit rnd_start);
    outs_t got;
    build_expect(instr, w);
    ir = instr;
    obs_q.delete();
    for (int k = 0; k < exp_q.size(); k++) begin
      @(posedge clock); #1;
      if (k >= 1 && k <= 1 + w) mem_ready = (k == 1 + w);
      else                      mem_ready = 1'($urandom_range(0, 1));
      start = rnd_start ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clock);
      got = sample();
      obs_q.push_back(got);
      checks++;
      if (got !== exp_q[k]) begin
        failures++;
        $display("FAIL step ir=%h cycle=%0d got=%h expected=%h", instr, k, got, exp_q[k]);
      end
    end
  endtask

  initial begin
    logic [15:0] rout_y, rout_op, rin_all;
    logic [4:0]  op_seen, rop;
    int          reads, lohi, ills, pick;
    logic [31:0] instr;

    legal_ops = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11,
                  5'd15, 5'd16, 5'd17, 5'd18, 5'd26, 5'd3};
    //           instr          w  rout_y    rout_op   rin_all   op     rd lohi ill
    vecs[0] = '{32'h389A8000, 0, 16'h0008, 16'h0020, 16'h0002, 5'h07, 1, 0, 0};
    vecs[1] = '{32'h18918000, 3, 16'h0004, 16'h0008, 16'h0002, 5'h03, 4, 0, 0};
    vecs[2] = '{32'h79180000, 0, 16'h0004, 16'h0008, 16'h0000, 5'h0F, 1, 2, 0};
    vecs[3] = '{32'h8A480000, 0, 16'h0000, 16'h0200, 16'h0010, 5'h11, 1, 0, 0};
    vecs[4] = '{32'hF8000000, 1, 16'h0000, 16'h0000, 16'h0000, 5'h00, 2, 0, 1};
    vecs[5] = '{32'hD0000000, 0, 16'h0000, 16'h0000, 16'h0000, 5'h00, 1, 0, 0};
    vecs[6] = '{32'h1AAA8000, 2, 16'h0020, 16'h0020, 16'h0020, 5'h03, 3, 0, 0};
    vecs[7] = '{32'h20078000, 0, 16'h0001, 16'h8000, 16'h0001, 5'h04, 1, 0, 0};

    clear = 1'b1; start = 1'b0; mem_ready = 1'b0; ir = 32'h0;
    #2;
    check_outs("reset_async", sample(), '0);
    @(negedge clock);
    clear = 1'b0;
    @(negedge clock);
    check_outs("reset_idle", sample(), '0);
    start = 1'b1;

    // Table vectors, each followed directly by the next fetch
    for (int v = 0; v < 8; v++) begin
      run_instr(vecs[v].instr, vecs[v].w, 1'b1);
      rout_y = '0; rout_op = '0; rin_all = '0; op_seen = '0;
      reads = 0; lohi = 0; ills = 0;
      foreach (obs_q[i]) begin
        if (obs_q[i].y_in) rout_y |= obs_q[i].rout;
        if (obs_q[i].operation != 5'd0) begin
          rout_op |= obs_q[i].rout;
          op_seen |= obs_q[i].operation;
        end
        rin_all |= obs_q[i].rin;
        reads += int'(obs_q[i].read);
        lohi  += int'(obs_q[i].lo_in) + int'(obs_q[i].hi_in);
        ills  += int'(obs_q[i].illegal);
      end
      check_val($sformatf("vec%0d_rout_y", v), 32'(rout_y), 32'(vecs[v].rout_y));
      check_val($sformatf("vec%0d_rout_op", v), 32'(rout_op), 32'(vecs[v].rout_op));
      check_val($sformatf("vec%0d_rin", v), 32'(rin_all), 32'(vecs[v].rin_all));
      check_val($sformatf("vec%0d_op", v), 32'(op_seen), 32'(vecs[v].op_seen));
      check_val($sformatf("vec%0d_reads", v), 32'(reads), 32'(vecs[v].reads));
      check_val($sformatf("vec%0d_lohi", v), 32'(lohi), 32'(vecs[v].lohi));
      check_val($sformatf("vec%0d_illegal", v), 32'(ills), 32'(vecs[v].ills));
    end

    // Randomized legal/illegal stream
    for (int n = 0; n < 60; n++) begin
      pick = $urandom_range(0, 16);
      if (pick == 15)      rop = 5'd31;
      else if (pick == 16) rop = 5'd12;
      else                 rop = legal_ops[pick];
      instr = {rop, 27'($urandom)};
      run_instr(instr, $urandom_range(0, 3), 1'b1);
    end

    // Halt, idle ten cycles, then resume with start
    run_instr(32'hD8000000, 0, 1'b0);
    for (int c = 0; c < 10; c++) begin
      @(posedge clock); #1;
      mem_ready = 1'($urandom_range(0, 1));
      @(negedge clock);
      check_outs($sformatf("halt_idle%0d", c), sample(), '0);
    end
    start = 1'b1;
    run_instr(32'h389A8000, 0, 1'b1);

    // Clear pulsed in T4 of an add
    ir = 32'h18918000;
    for (int k = 0; k < 5; k++) begin
      @(posedge clock); #1;
      mem_ready = 1'b1; start = 1'b0;
      @(negedge clock);
    end
    check_val("t4_rout_before_clear", 32'(Rout), 32'h0008);
    #2 clear = 1'b1;
    #1 check_outs("clear_async", sample(), '0);
    #1 clear = 1'b0;
    @(negedge clock);
    check_outs("clear_idle", sample(), '0);
    start = 1'b1;
    run_instr(32'h79180000, 1, 1'b1);
    run_instr(32'h8A480000, 0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
